// File: rtl/ysyx_220053_lsu.sv
// Handshaked load/store unit: one MemOp request becomes one or two aligned bus beats and one response.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: misaligned ops are legal and boundary crossers take two beats.
module ysyx_220053_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        WAIT0 = 3'd2,
        BEAT1 = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        WAIT0 = 3'd2,
        RESP  = 3'd5
    } state_t;
`endif

    state_t state_r, state_nx;

    logic [2:0]        op_r;
    logic              wen_r;
    logic [OFFW-1:0]   off_r;

    logic              req_ready_r, resp_valid_r, resp_err_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic              mem_req_valid_r, mem_req_wen_r;
    logic [ADDR_W-1:0] mem_req_addr_r;
    logic [XLEN-1:0]   mem_req_wdata_r;
    logic [BYTES-1:0]  mem_req_wmask_r;

    logic [3:0]        size_s;
    logic [OFFW-1:0]   off_s;
    logic              illegal_s, bad_s;
    logic [BYTES-1:0]  ones_s;
    logic [XLEN-1:0]   wfield_s;
    logic [XLEN-1:0]   lane_data0_s;
    logic [BYTES-1:0]  lane_mask0_s;
    logic [2*XLEN-1:0] merged_s;
    logic [XLEN-1:0]   field_s, load_s;

    function automatic logic [3:0] op_size(input logic [1:0] sz);
        case (sz)
            2'b01:   op_size = 4'd1;
            2'b10:   op_size = 4'd2;
            2'b00:   op_size = 4'd4;
            default: op_size = 4'd8;
        endcase
    endfunction

    // Decode the incoming request: access size, legality and the store bytes that survive
    always_comb begin
        size_s    = op_size(req_op[1:0]);
        off_s     = req_addr[OFFW-1:0];
        illegal_s = (req_op == 3'b111) || (req_wen && req_op[2]) ||
                    ((XLEN == 32) && (req_op[1:0] == 2'b11));
        ones_s    = {BYTES{1'b0}};
        wfield_s  = {XLEN{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            ones_s[i]          = (4'(i) < size_s);
            wfield_s[i*8 +: 8] = (4'(i) < size_s) ? req_wdata[i*8 +: 8] : 8'd0;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        bad_s = illegal_s;
`else
        bad_s = illegal_s || ((req_addr[2:0] & 3'(size_s - 4'd1)) != 3'd0);
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2*XLEN-1:0]  data2_s;
    logic [2*BYTES-1:0] mask2_s;
    logic               two_beat_s;
    logic [XLEN-1:0]    data_hi_r;
    logic [BYTES-1:0]   mask_hi_r;
    logic               two_r;
    logic [XLEN-1:0]    rd0_r;

    assign data2_s      = {{XLEN{1'b0}}, wfield_s} << {off_s, 3'b000};
    assign mask2_s      = {{BYTES{1'b0}}, ones_s} << off_s;
    assign lane_data0_s = data2_s[XLEN-1:0];
    assign lane_mask0_s = mask2_s[BYTES-1:0];
    assign two_beat_s   = (5'(off_s) + 5'(size_s)) > 5'(BYTES);

    // Upper-half lanes and first read beat for boundary-crossing ops
    always_ff @(posedge clk) begin
        if (rst) begin
            data_hi_r <= {XLEN{1'b0}};
            mask_hi_r <= {BYTES{1'b0}};
            two_r     <= 1'b0;
            rd0_r     <= {XLEN{1'b0}};
        end else begin
            if (state_r == IDLE && req_valid) begin
                data_hi_r <= data2_s[2*XLEN-1:XLEN];
                mask_hi_r <= mask2_s[2*BYTES-1:BYTES];
                two_r     <= two_beat_s;
            end
            if (state_r == WAIT0 && mem_rsp_valid) begin
                rd0_r <= mem_rsp_rdata;
            end
        end
    end
`else
    assign lane_data0_s = wfield_s << {off_s, 3'b000};
    assign lane_mask0_s = ones_s << off_s;
`endif

    // Merge beat data, shift the addressed field down and extend it
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_r == WAIT1) begin
            merged_s = {mem_rsp_rdata, rd0_r};
        end else begin
            merged_s = {{XLEN{1'b0}}, mem_rsp_rdata};
        end
`else
        merged_s = {{XLEN{1'b0}}, mem_rsp_rdata};
`endif
        field_s = XLEN'(merged_s >> {off_r, 3'b000});
        case (op_r[1:0])
            2'b01: begin
                if (op_r[2]) load_s = XLEN'(field_s[7:0]);
                else         load_s = XLEN'($signed(field_s[7:0]));
            end
            2'b10: begin
                if (op_r[2]) load_s = XLEN'(field_s[15:0]);
                else         load_s = XLEN'($signed(field_s[15:0]));
            end
            2'b00: begin
                if (op_r[2]) load_s = XLEN'(field_s[31:0]);
                else         load_s = XLEN'($signed(field_s[31:0]));
            end
            default: load_s = field_s;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_nx = bad_s ? RESP : BEAT0;
                else           state_nx = IDLE;
            end
            BEAT0: begin
                if (mem_req_ready) state_nx = WAIT0;
                else               state_nx = BEAT0;
            end
            WAIT0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (mem_rsp_valid) state_nx = two_r ? BEAT1 : RESP;
                else               state_nx = WAIT0;
`else
                if (mem_rsp_valid) state_nx = RESP;
                else               state_nx = WAIT0;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_req_ready) state_nx = WAIT1;
                else               state_nx = BEAT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_nx = RESP;
                else               state_nx = WAIT1;
            end
`endif
            RESP: begin
                if (resp_ready) state_nx = IDLE;
                else            state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and request fields held for the whole op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= 3'd0;
            wen_r   <= 1'b0;
            off_r   <= {OFFW{1'b0}};
        end else begin
            state_r <= state_nx;
            if (state_r == IDLE && req_valid) begin
                op_r  <= req_op;
                wen_r <= req_wen;
                off_r <= off_s;
            end
        end
    end

    // Registered handshake, bus and response outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r     <= 1'b1;
            resp_valid_r    <= 1'b0;
            resp_err_r      <= 1'b0;
            resp_rdata_r    <= {XLEN{1'b0}};
            mem_req_valid_r <= 1'b0;
            mem_req_wen_r   <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            mem_req_wdata_r <= {XLEN{1'b0}};
            mem_req_wmask_r <= {BYTES{1'b0}};
        end else begin
            req_ready_r <= (state_nx == IDLE);
`ifdef LSU_MISALIGN_SPLIT_EN
            mem_req_valid_r <= (state_nx == BEAT0) || (state_nx == BEAT1);
`else
            mem_req_valid_r <= (state_nx == BEAT0);
`endif
            if (state_r == IDLE && state_nx == BEAT0) begin
                mem_req_addr_r  <= req_addr & ~ADDR_W'(BYTES - 1);
                mem_req_wen_r   <= req_wen;
                mem_req_wdata_r <= req_wen ? lane_data0_s : {XLEN{1'b0}};
                mem_req_wmask_r <= req_wen ? lane_mask0_s : {BYTES{1'b0}};
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if (state_r == WAIT0 && state_nx == BEAT1) begin
                mem_req_addr_r  <= mem_req_addr_r + ADDR_W'(BYTES);
                mem_req_wdata_r <= wen_r ? data_hi_r : {XLEN{1'b0}};
                mem_req_wmask_r <= wen_r ? mask_hi_r : {BYTES{1'b0}};
            end
`endif
            if (state_nx == RESP && state_r != RESP) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= (state_r == IDLE);
                resp_rdata_r <= (state_r != IDLE && !wen_r) ? load_s : {XLEN{1'b0}};
            end else if (state_r == RESP && resp_ready) begin
                resp_valid_r <= 1'b0;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= {XLEN{1'b0}};
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_err      = resp_err_r;
    assign resp_rdata    = resp_rdata_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_wen   = mem_req_wen_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;
    assign mem_req_wmask = mem_req_wmask_r;

endmodule
